pipe_track: RTL and testbench

- Producer-side companion to the ID-stage hazard controller.
- Carries destination-register metadata (rd, regWrite, isLoad, valid) for each in-flight instruction through the EX, MEM and WB stages.
- Drives the ex_*/mem_* inputs that the hazard unit consumes. Applies the hazard unit's stall as bubble insertion and the data-memory wait as a full pipeline freeze.
- Keeps saturating performance counters for retired instructions, stall cycles, flushes and freeze cycles.

---
 rtl/pipe_track_if.sv | 54 +++++
 rtl/pipe_track.sv | 142 ++++++++++++++
 tb/tb_pipe_track.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_track_if.sv
// rtl/pipe_track_if.sv - signal bundle between the pipeline driver and pipe_track
//
// Purpose: groups every non-clock/reset signal of pipe_track.
//   ID side in : id_valid, id_rd, id_regWrite, id_isLoad
//   control in : stall, flush, mem_stall, clr_cnt
//   stage out  : ex_rd/ex_regWrite/ex_isLoad, mem_rd/mem_regWrite/mem_isLoad,
//                wb_rd/wb_regWrite
//   counters   : retired_cnt, stall_cnt, flush_cnt, freeze_cnt
// Modports: master drives ID/control and observes outputs; slave is pipe_track.
interface pipe_track_if #(
    parameter int CNT_W   = 32,
    parameter int RADDR_W = 5
);
    logic               id_valid;
    logic [RADDR_W-1:0] id_rd;
    logic               id_regWrite;
    logic               id_isLoad;
    logic               stall;
    logic               flush;
    logic               mem_stall;
    logic               clr_cnt;

    logic [RADDR_W-1:0] ex_rd;
    logic               ex_regWrite;
    logic               ex_isLoad;
    logic [RADDR_W-1:0] mem_rd;
    logic               mem_regWrite;
    logic               mem_isLoad;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_regWrite;

    logic [CNT_W-1:0]   retired_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   freeze_cnt;

    modport master (
        output id_valid, id_rd, id_regWrite, id_isLoad,
        output stall, flush, mem_stall, clr_cnt,
        input  ex_rd, ex_regWrite, ex_isLoad,
        input  mem_rd, mem_regWrite, mem_isLoad,
        input  wb_rd, wb_regWrite,
        input  retired_cnt, stall_cnt, flush_cnt, freeze_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_regWrite, id_isLoad,
        input  stall, flush, mem_stall, clr_cnt,
        output ex_rd, ex_regWrite, ex_isLoad,
        output mem_rd, mem_regWrite, mem_isLoad,
        output wb_rd, wb_regWrite,
        output retired_cnt, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/pipe_track.sv
// rtl/pipe_track.sv - EX/MEM/WB destination-register tracker with perf counters
//
// Purpose: carries {valid, rd, regWrite, isLoad} of each in-flight instruction
// through EX, MEM and WB for the ID-stage hazard unit. stall inserts a bubble
// into EX, mem_stall freezes every stage. Saturating counters track retired
// instructions, bubble cycles, flushes and freeze cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : pipe_track_if.slave (ID entry, controls, stage outputs, counters)
module pipe_track #(
    parameter int CNT_W   = 32,
    parameter int RADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_b,
    pipe_track_if.slave  bus
);

    logic               ex_valid_q,  ex_valid_d;
    logic [RADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic               ex_rw_q,     ex_rw_d;
    logic               ex_ld_q,     ex_ld_d;
    logic               mem_valid_q, mem_valid_d;
    logic [RADDR_W-1:0] mem_rd_q,    mem_rd_d;
    logic               mem_rw_q,    mem_rw_d;
    logic               mem_ld_q,    mem_ld_d;
    logic               wb_valid_q,  wb_valid_d;
    logic [RADDR_W-1:0] wb_rd_q,     wb_rd_d;
    logic               wb_rw_q,     wb_rw_d;

    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   stall_q,   stall_d;
    logic [CNT_W-1:0]   flush_q,   flush_d;
    logic [CNT_W-1:0]   freeze_q,  freeze_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_rw_d     = ex_rw_q;
        ex_ld_d     = ex_ld_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_rw_d    = mem_rw_q;
        mem_ld_d    = mem_ld_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;

        if (!bus.mem_stall) begin
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            wb_rw_d     = mem_rw_q;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_rw_d    = ex_rw_q;
            mem_ld_d    = ex_ld_q;
            if (bus.stall) begin
                ex_valid_d = 1'b0;
                ex_rd_d    = '0;
                ex_rw_d    = 1'b0;
                ex_ld_d    = 1'b0;
            end else begin
                // Every field is gated by id_valid so garbage on an empty slot
                // never reaches the stage registers; $zero is never a writer.
                ex_valid_d = bus.id_valid;
                ex_rd_d    = bus.id_valid ? bus.id_rd : '0;
                ex_rw_d    = bus.id_valid & bus.id_regWrite & (bus.id_rd != '0);
                ex_ld_d    = bus.id_valid & bus.id_isLoad;
            end
        end
    end

    always_comb begin
        retired_d = '0;
        stall_d   = '0;
        flush_d   = '0;
        freeze_d  = '0;
        if (!bus.clr_cnt) begin
            retired_d = sat_inc(retired_q, wb_valid_q & ~bus.mem_stall);
            stall_d   = sat_inc(stall_q,   bus.stall  & ~bus.mem_stall);
            // A flush held through a freeze is seen only on the release edge.
            flush_d   = sat_inc(flush_q,   bus.flush  & ~bus.mem_stall);
            freeze_d  = sat_inc(freeze_q,  bus.mem_stall);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            retired_q   <= '0;
            stall_q     <= '0;
            flush_q     <= '0;
            freeze_q    <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_ld_q     <= ex_ld_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            mem_ld_q    <= mem_ld_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            retired_q   <= retired_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            freeze_q    <= freeze_d;
        end
    end

    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_regWrite  = ex_rw_q;
    assign bus.ex_isLoad    = ex_ld_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_regWrite = mem_rw_q;
    assign bus.mem_isLoad   = mem_ld_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_regWrite  = wb_rw_q;
    assign bus.retired_cnt  = retired_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
    assign bus.freeze_cnt   = freeze_q;

endmodule

// File: tb/tb_pipe_track.sv
// tb/tb_pipe_track.sv - self-checking bench for pipe_track
module tb_pipe_track;

    localparam int CNT_W   = 4;
    localparam int RADDR_W = 5;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int VW      = 3 * RADDR_W + 5 + 4 * CNT_W;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    pipe_track_if #(.CNT_W(CNT_W), .RADDR_W(RADDR_W)) bus ();

    pipe_track #(.CNT_W(CNT_W), .RADDR_W(RADDR_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct {
        logic               v;
        logic [RADDR_W-1:0] rd;
        logic               rw;
        logic               ld;
    } ent_t;

    ent_t m_pipe[3];
    int   m_ret, m_stl, m_fl, m_frz;
    int   errors = 0;
    int   checks = 0;

    function automatic int sat(input int c);
        return (c < MAXC) ? c + 1 : c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '{1'b0, '0, 1'b0, 1'b0};
        m_ret = 0; m_stl = 0; m_fl = 0; m_frz = 0;
    endfunction

    // Pipeline as a 3-slot shift array: index 0=EX, 1=MEM, 2=WB.
    function automatic void model_edge();
        ent_t nxt;
        nxt = '{1'b0, '0, 1'b0, 1'b0};
        if (bus.id_valid === 1'b1) begin
            nxt.v  = 1'b1;
            nxt.rd = bus.id_rd;
            nxt.rw = (bus.id_regWrite === 1'b1) && (bus.id_rd != 0);
            nxt.ld = (bus.id_isLoad === 1'b1);
        end
        if (bus.clr_cnt) begin
            m_ret = 0; m_stl = 0; m_fl = 0; m_frz = 0;
        end else if (bus.mem_stall) begin
            m_frz = sat(m_frz);
        end else begin
            if (m_pipe[2].v) m_ret = sat(m_ret);
            if (bus.stall)   m_stl = sat(m_stl);
            if (bus.flush)   m_fl  = sat(m_fl);
        end
        if (!bus.mem_stall) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = bus.stall ? '{1'b0, '0, 1'b0, 1'b0} : nxt;
        end
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.ex_rd, bus.ex_regWrite, bus.ex_isLoad,
                bus.mem_rd, bus.mem_regWrite, bus.mem_isLoad,
                bus.wb_rd, bus.wb_regWrite,
                bus.retired_cnt, bus.stall_cnt, bus.flush_cnt, bus.freeze_cnt};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_pipe[0].rd, m_pipe[0].rw, m_pipe[0].ld,
                m_pipe[1].rd, m_pipe[1].rw, m_pipe[1].ld,
                m_pipe[2].rd, m_pipe[2].rw,
                CNT_W'(m_ret), CNT_W'(m_stl), CNT_W'(m_fl), CNT_W'(m_frz)};
    endfunction

    task automatic set_id(input logic v, input logic [RADDR_W-1:0] rd, input logic rw, input logic ld);
        bus.id_valid = v; bus.id_rd = rd; bus.id_regWrite = rw; bus.id_isLoad = ld;
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic ms, input logic clr);
        bus.stall = st; bus.flush = fl; bus.mem_stall = ms; bus.clr_cnt = clr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_counters();
        set_id(1'b0, '0, 1'b0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        bus.clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        set_id(1'b0, '0, 1'b0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
        end
        #11 rst_b = 1'b1;
    endtask

    task automatic test_load_add();
        set_id(1'b1, 5'd8, 1'b1, 1'b1);
        step();
        checks++;
        if ({bus.ex_rd, bus.ex_isLoad} !== {5'd8, 1'b1}) begin
            errors++;
            $display("FAIL lw_in_ex got rd=%0d ld=%b exp rd=8 ld=1", bus.ex_rd, bus.ex_isLoad);
        end
        set_id(1'b1, 5'd9, 1'b1, 1'b0);
        step();
        checks++;
        if ({bus.ex_rd, bus.ex_isLoad, bus.mem_rd, bus.mem_isLoad} !== {5'd9, 1'b0, 5'd8, 1'b1}) begin
            errors++;
            $display("FAIL add_ex_lw_mem got ex=%0d/%b mem=%0d/%b exp ex=9/0 mem=8/1",
                     bus.ex_rd, bus.ex_isLoad, bus.mem_rd, bus.mem_isLoad);
        end
        set_id(1'b0, '0, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.wb_rd, bus.wb_regWrite} !== {5'd8, 1'b1}) begin
            errors++;
            $display("FAIL lw_in_wb got rd=%0d rw=%b exp rd=8 rw=1", bus.wb_rd, bus.wb_regWrite);
        end
        step();
        checks++;
        if (bus.retired_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL lw_retired got=%0d exp=1", bus.retired_cnt);
        end
    endtask

    task automatic test_zero_rd();
        int r0;
        clear_counters();
        step(); step(); step();
        r0 = m_ret;
        set_id(1'b1, 5'd0, 1'b1, 1'b0);
        step();
        checks++;
        if ({bus.ex_rd, bus.ex_regWrite} !== {5'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_rd_ex got rd=%0d rw=%b exp rd=0 rw=0", bus.ex_rd, bus.ex_regWrite);
        end
        set_id(1'b0, '0, 1'b0, 1'b0);
        step(); step();
        checks++;
        if (bus.retired_cnt !== CNT_W'(r0)) begin
            errors++;
            $display("FAIL zero_rd_not_yet got=%0d exp=%0d", bus.retired_cnt, r0);
        end
        step();
        checks++;
        if (bus.retired_cnt !== CNT_W'(r0 + 1)) begin
            errors++;
            $display("FAIL zero_rd_retired got=%0d exp=%0d", bus.retired_cnt, r0 + 1);
        end
    endtask

    task automatic test_stall();
        clear_counters();
        set_id(1'b1, 5'd5, 1'b1, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.ex_rd, bus.ex_regWrite, bus.ex_isLoad} !== 7'd0) begin
                errors++;
                $display("FAIL stall_bubble%0d got rd=%0d rw=%b ld=%b exp zero",
                         i, bus.ex_rd, bus.ex_regWrite, bus.ex_isLoad);
            end
        end
        bus.stall = 1'b0;
        step();
        checks++;
        if ({bus.ex_rd, bus.ex_regWrite, bus.stall_cnt} !== {5'd5, 1'b1, CNT_W'(2)}) begin
            errors++;
            $display("FAIL stall_release got rd=%0d rw=%b cnt=%0d exp rd=5 rw=1 cnt=2",
                     bus.ex_rd, bus.ex_regWrite, bus.stall_cnt);
        end
    endtask

    task automatic test_freeze();
        int r0;
        for (int k = 1; k <= 3; k++) begin
            set_id(1'b1, RADDR_W'(k), 1'b1, 1'b0);
            step();
        end
        clear_counters();
        // clear_counters itself advanced once; rebuild 3/2/1 without counting.
        for (int k = 1; k <= 3; k++) begin
            set_id(1'b1, RADDR_W'(k), 1'b1, 1'b0);
            step();
        end
        r0 = m_ret;
        set_id(1'b1, 5'd20, 1'b1, 1'b1);
        set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.ex_rd, bus.mem_rd, bus.wb_rd} !== {5'd3, 5'd2, 5'd1}) begin
                errors++;
                $display("FAIL freeze_hold%0d got %0d/%0d/%0d exp 3/2/1",
                         i, bus.ex_rd, bus.mem_rd, bus.wb_rd);
            end
        end
        checks++;
        if ({bus.freeze_cnt, bus.flush_cnt, bus.stall_cnt, bus.retired_cnt} !==
            {CNT_W'(3), CNT_W'(0), CNT_W'(0), CNT_W'(r0)}) begin
            errors++;
            $display("FAIL freeze_counters got frz=%0d fl=%0d st=%0d ret=%0d exp 3/0/0/%0d",
                     bus.freeze_cnt, bus.flush_cnt, bus.stall_cnt, bus.retired_cnt, r0);
        end
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.flush_cnt, bus.freeze_cnt} !== {CNT_W'(1), CNT_W'(3)}) begin
            errors++;
            $display("FAIL freeze_release_flush got fl=%0d frz=%0d exp 1/3",
                     bus.flush_cnt, bus.freeze_cnt);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL freeze_release_model got=%h exp=%h", dut_vec(), model_vec());
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        clear_counters();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bus.stall_cnt !== CNT_W'(MAXC)) begin
            errors++;
            $display("FAIL stall_saturate got=%0d exp=%0d", bus.stall_cnt, MAXC);
        end
        bus.clr_cnt = 1'b1;
        step();
        checks++;
        if (bus.stall_cnt !== CNT_W'(0)) begin
            errors++;
            $display("FAIL clr_over_stall got=%0d exp=0", bus.stall_cnt);
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_id(1'b1, RADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            end else begin
                bus.id_valid = 1'b0;
                bus.id_rd = 'x; bus.id_regWrite = 1'bx; bus.id_isLoad = 1'bx;
            end
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 3; k++) begin
            set_id(1'b1, RADDR_W'(k + 10), 1'b1, 1'b1);
            step();
        end
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        #2 rst_b = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        #2 rst_b = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        set_id(1'b1, 5'd7, 1'b1, 1'b0);
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL after_async_reset got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_zero_rd();
        test_stall();
        test_freeze();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
